// File: rtl/hps_button_debounce.sv
// Per-channel 2-flop synchronizer + persistence counter; out_port updates DEBOUNCE_CYCLES+1 edges after a held change.
// Free-running, no backpressure; fall/rise strobes are registered and last one cycle.
module hps_button_debounce #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] rise_pulse
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] fall_next;
    logic [WIDTH-1:0] rise_next;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];

    // A channel is COUNTING whenever sync2 differs from stable; any agreement restarts the count.
    always_comb begin
        stable_next = stable;
        fall_next   = '0;
        rise_next   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == LAST) begin
                    stable_next[i] = sync2[i];
                    fall_next[i]   = ~sync2[i];
                    rise_next[i]   = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1      <= IDLE_LEVEL;
            sync2      <= IDLE_LEVEL;
            stable     <= IDLE_LEVEL;
            fall_pulse <= '0;
            rise_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= button_in;
            sync2      <= sync1;
            stable     <= stable_next;
            fall_pulse <= fall_next;
            rise_pulse <= rise_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign out_port = stable;

endmodule

// File: doc/hps_button_debounce.md
HPS_BUTTON_DEBOUNCE -- requirements
Module: hps_button_debounce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port is clk and the reset port is reset_n.
REQ-002 Parameter WIDTH, default 2: number of independent button channels.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles a changed level must persist before acceptance; legal range 1..2^24-1.
REQ-004 Parameter IDLE_LEVEL, default {WIDTH{1'b1}}: released level of each button (active-low keys).
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 button_in  input  WIDTH  raw asynchronous button pins.
REQ-008 out_port  output  WIDTH  debounced levels; drives in_port of the downstream button PIO.
REQ-009 fall_pulse  output  WIDTH  one-cycle strobe per channel on an accepted 1->0 transition of out_port.
REQ-010 rise_pulse  output  WIDTH  one-cycle strobe per channel on an accepted 0->1 transition of out_port.

Function
REQ-011 Each channel SHALL pass button_in through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits and a stable register driving out_port.
REQ-013 States per channel: IDLE (sync2 == stable, counter 0) and COUNTING (sync2 != stable).
REQ-014 In IDLE, counter SHALL stay 0 and stable SHALL be unchanged.
REQ-015 In COUNTING with counter < DEBOUNCE_CYCLES-1, counter SHALL increment by 1 per cycle.
REQ-016 In COUNTING with counter == DEBOUNCE_CYCLES-1, on the next edge stable SHALL load sync2 and counter SHALL clear to 0.
REQ-017 Any cycle with sync2 == stable SHALL clear counter to 0 (glitch rejection); counting restarts from 0 on the next difference.
REQ-018 Latency: button_in changed before edge N and held SHALL update out_port at edge N+1+DEBOUNCE_CYCLES.
REQ-019 With DEBOUNCE_CYCLES = 1, out_port SHALL follow sync2 with one extra register stage (update at edge N+2).
REQ-020 fall_pulse[i]/rise_pulse[i] SHALL be registered, asserted in the cycle immediately after the edge at which stable[i] changes, and last exactly one cycle.
REQ-021 fall_pulse[i] and rise_pulse[i] SHALL never be asserted in the same cycle.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on their own schedule.
REQ-023 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-024 A pulse shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL produce no change on out_port and no strobe.

Reset
REQ-025 While reset_n is low at a rising edge: sync1, sync2 and out_port SHALL load IDLE_LEVEL, counters SHALL load 0, and fall_pulse and rise_pulse SHALL load 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after release, a held pressed level SHALL take the full REQ-018 latency measured from the first edge with reset_n high.
REQ-027 No output SHALL change asynchronously to clk.

Verification (bench uses WIDTH=2, DEBOUNCE_CYCLES=4, IDLE_LEVEL=2'b11)
REQ-028 Reset 3 cycles with button_in=2'b00 -> out_port=2'b11 and both pulse buses 0 throughout reset; first cycle after release still 2'b11.
REQ-029 button_in[0] 1->0 before edge N, held -> out_port=2'b10 at edge N+5; fall_pulse=2'b01 only during cycle N+5..N+6; rise_pulse stays 0.
REQ-030 button_in[0] low for 3 cycles then high -> out_port stays 2'b11, no strobes; then low for 4+ cycles -> accepted per REQ-018.
REQ-031 Both bits 1->0 at same edge, bit1 released after 2 cycles -> only bit0 changes (out_port=2'b10), single fall_pulse=2'b01.
REQ-032 reset_n low for 1 cycle while channel 0 is counting at counter=2 -> no change; after release out_port[0] falls 5 edges after the first edge with reset_n high.
REQ-033 Bit0 pressed then released after acceptance -> rise_pulse=2'b01 for exactly one cycle, 5 edges after release; strobes never overlap.
